pc_branch_ctrl: RTL and testbench
=================================

# pc_branch_ctrl

Program-counter and branch-resolution stage of the i281 datapath, sitting directly downstream of the 4-bit flags register. Each instruction-advance cycle it evaluates the decoded branch condition against the registered flags and updates the 6-bit PC to either PC+1 or PC+1+offset. A small run/step/halt state machine gates advancement and exports the advance strobe that qualifies every other architectural state update, including the flags-register load enable.

## Interface
- No parameters; PC width fixed at 6 bits (64-word instruction memory).
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  continuous-execution enable (level)
- step  in  1  single-step request; rising edge detected internally
- halt_req  in  1  decoded HALT instruction at current PC
- jump  in  1  decoded unconditional relative jump
- branch  in  1  decoded conditional branch
- cond  in  3  branch condition select
- offset  in  6  signed two's-complement displacement, range -32..+31
- flags  in  4  flags-register output: [3]=C, [2]=O, [1]=N, [0]=Z
- pc  out  6  current program counter (registered)
- pc_en  out  1  advance strobe; high in the cycle the PC updates
- taken  out  1  high in an advance cycle whose jump/branch redirects the PC
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 HALTED
- halted  out  1  high while state is HALTED

## Operation
- Reset: pc=0, state=IDLE, step edge register=1 (a step held through reset release causes no advance), pc_en=0, taken=0, halted=0.
- step_pulse = step & ~step_q; step_q <= step every cycle.
- advance (pc_en) = (state==RUN & run) | (state==IDLE & step_pulse); combinational.
- FSM:
  - IDLE: run=1 -> RUN. A step_pulse causes exactly one advance and stays IDLE. If run=1 and step_pulse coincide, the pulse advances once and the state enters RUN.
  - RUN: run=0 -> IDLE, with no advance in that cycle.
  - Any state, advance with halt_req=1 -> HALTED.
  - HALTED: terminal; exits only through reset. run and step are ignored.
- Condition decode (cond_true):
  - 0 BRZ: Z
  - 1 BRNZ: ~Z
  - 2 BRG: ~Z & (N==O)
  - 3 BRGE: N==O
  - 4 BRC: C
  - 5 BRNC: ~C
  - 6 BRN: N
  - 7 always true
- Next PC in an advance cycle, in priority order:
  - halt_req: pc unchanged, taken=0.
  - jump: pc+1+offset, taken=1.
  - branch & cond_true: pc+1+offset, taken=1.
  - Otherwise: pc+1, taken=0.
- Arithmetic: offset sign-extended, sum computed in 6 bits modulo 64. Wrap is silent (63+1=0; 0+1+(-2)=63).
- Outside advance cycles pc holds and taken=0. jump/branch/halt_req inputs are ignored.
- flags are sampled only during advance and are not latched here.

## Timing
- Zero-cycle decision: pc_en, taken and cond_true are combinational in the advance cycle. The new pc is visible one clock later.
- Flag dependency: a compare retired in advance cycle k loads flags at edge k. A branch in advance cycle k+1 sees those flags. No bypass, no stall.
- RUN steady state: one advance per clock, so PC throughput is 1 instruction/cycle.
- IDLE->RUN costs one non-advancing cycle after run rises. run falling stops advancement in the same cycle it is sampled low in RUN.
- Reset mid-operation: outputs return to reset values immediately, asynchronously. The first advance occurs no earlier than the first clock after reset deasserts.

## Test plan
- Reset/step: hold step=1 across reset release -> no advance. Drop step, then pulse step 3 times (each held 4 cycles) -> pc 0->1->2->3, exactly 3 pc_en pulses, state stays 00.
- Run and wrap: pc=62, run=1, no branches -> pc 62,63,0,1 on consecutive clocks. Drop run -> pc freezes and state=00 next cycle.
- Conditions: for each cond 0..7, sweep all 16 flag values with branch=1, offset=+5, pc=10 -> pc=16 iff cond_true per table, else 11. taken matches.
- Negative offset wrap: pc=1, jump=1, offset=-4 -> pc=62, taken=1. branch=1, cond=7, offset=-1 -> pc unchanged (self-loop).
- Priority: halt_req=jump=branch=1 at pc=20 -> pc stays 20, taken=0, state=10, halted=1. Further run/step -> no change. Reset -> pc=0, state=00.
- Reset mid-run: assert reset asynchronously between edges while pc=37 -> pc=0, pc_en=0 before the next edge.

Source files
------------

// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// pc_branch_ctrl -- i281 program counter, branch resolution and run/step/halt
// Revision: 1.0
// ============================================================================
module pc_branch_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       halt_req,
  input  logic       jump,
  input  logic       branch,
  input  logic [2:0] cond,
  input  logic [5:0] offset,
  input  logic [3:0] flags,
  output logic [5:0] pc,
  output logic       pc_en,
  output logic       taken,
  output logic [1:0] state,
  output logic       halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t     state_r;
  state_t     state_nx;
  logic       step_q;
  logic       step_pulse;
  logic       advance;
  logic       cond_true;
  logic       redirect;
  logic [5:0] pc_inc;
  logic [5:0] pc_nx;

  wire flag_c = flags[3];
  wire flag_o = flags[2];
  wire flag_n = flags[1];
  wire flag_z = flags[0];

  assign step_pulse = step & ~step_q;
  assign advance    = ((state_r == RUN) & run) | ((state_r == IDLE) & step_pulse);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0: cond_true = flag_z;
      3'd1: cond_true = ~flag_z;
      3'd2: cond_true = ~flag_z & (flag_n == flag_o);
      3'd3: cond_true = (flag_n == flag_o);
      3'd4: cond_true = flag_c;
      3'd5: cond_true = ~flag_c;
      3'd6: cond_true = flag_n;
      default: cond_true = 1'b1;
    endcase
  end

  // halt_req outranks any redirect decoded in the same instruction
  assign redirect = ~halt_req & (jump | (branch & cond_true));
  assign pc_inc   = pc + 6'd1;

  always_comb begin
    pc_nx = pc;
    if (advance && !halt_req) begin
      pc_nx = redirect ? (pc_inc + offset) : pc_inc;
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (advance && halt_req) state_nx = HALTED;
        else if (run)            state_nx = RUN;
      end
      RUN: begin
        if (advance && halt_req) state_nx = HALTED;
        else if (!run)           state_nx = IDLE;
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  // step_q resets high so a step held through reset release is not an edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      step_q  <= 1'b1;
      pc      <= 6'd0;
    end else begin
      state_r <= state_nx;
      step_q  <= step;
      pc      <= pc_nx;
    end
  end

  assign pc_en  = advance;
  assign taken  = advance & redirect;
  assign state  = state_r;
  assign halted = (state_r == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
// Self-checking bench for pc_branch_ctrl: directed sequences plus a
// table-driven sweep of every branch condition against all flag values.
module tb_pc_branch_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       run, step, halt_req, jump, branch;
  logic [2:0] cond;
  logic [5:0] offset;
  logic [3:0] flags;
  logic [5:0] pc;
  logic       pc_en, taken, halted;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic       s_en, s_taken;
  logic [5:0] exp_pc;

  typedef struct {
    logic [2:0] c;
    logic [3:0] f;
    logic       t;
    logic [5:0] p;
  } vec_t;
  vec_t vecs [128];

  pc_branch_ctrl dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .jump(jump), .branch(branch), .cond(cond), .offset(offset), .flags(flags),
    .pc(pc), .pc_en(pc_en), .taken(taken), .state(state), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Branch condition from the condition table, written per mnemonic
  function automatic logic cond_ref(input logic [2:0] c, input logic [3:0] f);
    logic cf, of, nf, zf;
    {cf, of, nf, zf} = f;
    case (c)
      3'd0: return zf;
      3'd1: return !zf;
      3'd2: return !zf && !(nf ^ of);
      3'd3: return !(nf ^ of);
      3'd4: return cf;
      3'd5: return !cf;
      3'd6: return nf;
      default: return 1'b1;
    endcase
  endfunction

  // Called at a negedge: drive, sample combinational outputs, cross one
  // rising edge, return at the following negedge.
  task automatic apply(input logic j, input logic b, input logic h, input logic [2:0] c,
                       input logic [5:0] o, input logic [3:0] f);
    jump = j; branch = b; halt_req = h; cond = c; offset = o; flags = f;
    #1;
    s_en    = pc_en;
    s_taken = taken;
    @(posedge clock);
    @(negedge clock);
    jump = 1'b0; branch = 1'b0; halt_req = 1'b0;
  endtask

  task automatic goto_run(input logic [5:0] target);
    logic [5:0] o;
    o = target - exp_pc - 6'd1;
    apply(1'b1, 1'b0, 1'b0, 3'd0, o, 4'd0);
    check("goto_taken", s_taken, 1);
    check("goto_pc", pc, target);
    exp_pc = target;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; run = 1'b0; step = 1'b1; halt_req = 1'b0; jump = 1'b0;
    branch = 1'b0; cond = 3'd0; offset = 6'd0; flags = 4'd0;

    for (int i = 0; i < 128; i++) begin
      vecs[i].c = 3'(i / 16);
      vecs[i].f = 4'(i % 16);
      vecs[i].t = cond_ref(vecs[i].c, vecs[i].f);
      vecs[i].p = vecs[i].t ? 6'd16 : 6'd11;
    end

    repeat (2) @(negedge clock);
    check("rst_pc", pc, 0);
    check("rst_state", state, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_taken", taken, 0);
    check("rst_halted", halted, 0);

    // step held high through reset release must not advance
    reset = 1'b0;
    cnt = 0;
    repeat (3) begin
      #1 cnt += int'(pc_en);
      @(negedge clock);
    end
    check("held_step_adv", cnt, 0);
    check("held_step_pc", pc, 0);

    step = 1'b0;
    repeat (2) @(negedge clock);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      repeat (4) begin
        #1 cnt += int'(pc_en);
        @(negedge clock);
      end
      step = 1'b0;
      repeat (4) begin
        #1 cnt += int'(pc_en);
        @(negedge clock);
      end
    end
    check("step_count", cnt, 3);
    check("step_pc", pc, 3);
    check("step_state", state, 0);

    // single step carrying a backward jump: 3+1+(-6) = 62
    step = 1'b1; jump = 1'b1; offset = 6'd58;
    #1;
    check("step_jump_en", pc_en, 1);
    check("step_jump_taken", taken, 1);
    @(negedge clock);
    step = 1'b0; jump = 1'b0;
    check("step_jump_pc", pc, 62);

    run = 1'b1;
    #1 check("idle_to_run_noadv", pc_en, 0);
    @(negedge clock);
    check("run_state", state, 1);
    check("run_pc0", pc, 62);
    @(negedge clock) check("run_pc1", pc, 63);
    @(negedge clock) check("run_pc_wrap", pc, 0);
    @(negedge clock) check("run_pc3", pc, 1);
    run = 1'b0;
    #1 check("run_drop_noadv", pc_en, 0);
    @(negedge clock);
    check("run_drop_pc", pc, 1);
    check("run_drop_state", state, 0);

    run = 1'b1;
    @(negedge clock);
    check("rerun_state", state, 1);
    exp_pc = 6'd1;

    for (int i = 0; i < 128; i++) begin
      goto_run(6'd10);
      apply(1'b0, 1'b1, 1'b0, vecs[i].c, 6'd5, vecs[i].f);
      check($sformatf("cond%0d_f%0h_taken", vecs[i].c, vecs[i].f), s_taken, vecs[i].t);
      check($sformatf("cond%0d_f%0h_pc", vecs[i].c, vecs[i].f), pc, vecs[i].p);
      exp_pc = vecs[i].p;
    end

    goto_run(6'd1);
    apply(1'b1, 1'b0, 1'b0, 3'd0, 6'h3C, 4'd0);
    check("neg_jump_taken", s_taken, 1);
    check("neg_jump_pc", pc, 62);
    apply(1'b0, 1'b1, 1'b0, 3'd7, 6'h3F, 4'd0);
    check("self_loop_taken", s_taken, 1);
    check("self_loop_pc", pc, 62);
    exp_pc = 6'd62;

    goto_run(6'd20);
    apply(1'b1, 1'b1, 1'b1, 3'd7, 6'd5, 4'hF);
    check("halt_en", s_en, 1);
    check("halt_taken", s_taken, 0);
    check("halt_pc", pc, 20);
    check("halt_state", state, 2);
    check("halt_halted", halted, 1);
    for (int k = 0; k < 4; k++) begin
      step = k[0];
      apply(1'b1, 1'b1, 1'b0, 3'd7, 6'd5, 4'd0);
      check("halted_noadv", s_en, 0);
      check("halted_pc", pc, 20);
      check("halted_state", state, 2);
    end
    step = 1'b0; run = 1'b0;
    reset = 1'b1;
    #1;
    check("halt_rst_pc", pc, 0);
    check("halt_rst_state", state, 0);
    check("halt_rst_halted", halted, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // asynchronous reset mid-run, between clock edges
    run = 1'b1;
    @(negedge clock);
    exp_pc = 6'd0;
    goto_run(6'd37);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_pc_en", pc_en, 0);
    check("mid_rst_state", state, 0);
    @(negedge clock);
    reset = 1'b0;
    run = 1'b0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
